// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifu_state_e;

  localparam int PC_STEP    = 4;
  localparam int IFU_ADDR_W = 32;
  localparam int IFU_INST_W = 32;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_tag_queue.sv
// Two-entry FIFO holding the PCs of in-flight fetches; Clear wins over Push.
module ifu_tag_queue #(
  parameter int Width = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Push,
  input  logic [Width-1:0] PushData,
  input  logic             Pop,
  input  logic             Clear,
  output logic [Width-1:0] Head
);

  logic [Width-1:0] ent0_q;
  logic [Width-1:0] ent1_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (Clear) begin
      cnt_q <= 2'd0;
    end else begin
      case ({Push, Pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= PushData;
          else               ent1_q <= PushData;
          if (cnt_q != 2'd2) cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Pop and push together: head moves up, new tag fills behind it.
          if (cnt_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= PushData;
          end else begin
            ent0_q <= PushData;
            cnt_q  <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Head = ent0_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited fetches, writes {pc, inst} to the buffer FIFO.
// Define IFU_PERF_EN to add the PerfIssueCnt/PerfDropCnt counters.
//   state | meaning
//   IDLE  | first cycle after reset, no issue
//   RUN   | issuing and forwarding responses
//   DRAIN | discarding stale responses after a redirect
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                   AddrWidth      = IFU_ADDR_W,
  parameter int                   InstWidth      = IFU_INST_W,
  parameter logic [AddrWidth-1:0] ResetPc        = AddrWidth'(32'h8000_0000),
  parameter int                   MaxOutstanding = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           Jump,
  input  logic [AddrWidth-1:0]           JumpAddr,
  output logic                           IReqValid,
  input  logic                           IReqReady,
  output logic [AddrWidth-1:0]           IReqAddr,
  input  logic                           IRespValid,
  input  logic [InstWidth-1:0]           IRespData,
  output logic [AddrWidth+InstWidth-1:0] FifoWData,
  output logic                           FifoWInc,
  input  logic                           WFull,
  input  logic                           W_Will_Full
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]                    PerfIssueCnt,
  output logic [31:0]                    PerfDropCnt
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]           state_q, state_d;
  logic [1:0]           out_q;
  logic [1:0]           drop_q, drop_d;
  logic [1:0]           stale;
  logic [AddrWidth-1:0] pc_q;
  logic [AddrWidth-1:0] tq_head;
  logic                 credit_ok;
  logic                 issue_fire;
  logic                 resp_live;
  logic                 resp_drop;

  // Credit keeps outstanding fetches plus FIFO occupancy within FIFO depth.
  always_comb begin
    credit_ok = 1'b0;
    case (out_q)
      2'd0:    credit_ok = !WFull;
      2'd1:    credit_ok = (MaxOutstanding == 2) && !WFull && !W_Will_Full;
      default: credit_ok = 1'b0;
    endcase
  end

  assign IReqValid  = !Rst && (state_q == ST_RUN) && !Jump && credit_ok;
  assign IReqAddr   = pc_q;
  assign issue_fire = IReqValid && IReqReady;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_live = IRespValid && (out_q != 2'd0);
  assign resp_drop = resp_live && ((drop_q != 2'd0) || Jump);
  assign FifoWInc  = !Rst && resp_live && !resp_drop;
  assign stale     = out_q - {1'b0, resp_live};

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        if (Jump && (stale != 2'd0)) begin
          state_d = ST_DRAIN;
          drop_d  = stale;
        end
      end
      ST_DRAIN: begin
        if (Jump) begin
          drop_d  = stale;
          state_d = (stale != 2'd0) ? ST_DRAIN : ST_RUN;
        end else if (resp_live && (drop_q != 2'd0)) begin
          drop_d = drop_q - 2'd1;
          if (drop_q == 2'd1) state_d = ST_RUN;
        end else if (drop_q == 2'd0) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      pc_q    <= ResetPc;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      out_q   <= out_q + {1'b0, issue_fire} - {1'b0, resp_live};
      if (Jump)            pc_q <= JumpAddr;
      else if (issue_fire) pc_q <= pc_q + AddrWidth'(PC_STEP);
    end
  end

  ifu_tag_queue #(.Width(AddrWidth)) u_tag_queue (
    .Clk      (Clk),
    .Rst      (Rst),
    .Push     (issue_fire),
    .PushData (pc_q),
    .Pop      (FifoWInc),
    .Clear    (Jump),
    .Head     (tq_head)
  );

  generate
    if (AddrWidth == IFU_ADDR_W && InstWidth == IFU_INST_W) begin : g_entry
      fetch_entry_t entry;
      always_comb begin
        entry.pc   = tq_head;
        entry.inst = IRespData;
      end
      assign FifoWData = FifoWInc ? entry : '0;
    end else begin : g_concat
      assign FifoWData = FifoWInc ? {tq_head, IRespData} : '0;
    end
  endgenerate

`ifdef IFU_PERF_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PerfIssueCnt <= 32'd0;
      PerfDropCnt  <= 32'd0;
    end else begin
      if (issue_fire) PerfIssueCnt <= PerfIssueCnt + 32'd1;
      if (resp_drop)  PerfDropCnt  <= PerfDropCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory model plus scoreboard of expected FIFO writes.
module tb_inst_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Jump;
  logic [31:0] JumpAddr;
  logic        IReqValid;
  logic        IReqReady;
  logic [31:0] IReqAddr;
  logic        IRespValid;
  logic [31:0] IRespData;
  logic [63:0] FifoWData;
  logic        FifoWInc;
  logic        WFull;
  logic        W_Will_Full;
`ifdef IFU_PERF_EN
  logic [31:0] PerfIssueCnt;
  logic [31:0] PerfDropCnt;
`endif

  inst_fetch_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Jump        (Jump),
    .JumpAddr    (JumpAddr),
    .IReqValid   (IReqValid),
    .IReqReady   (IReqReady),
    .IReqAddr    (IReqAddr),
    .IRespValid  (IRespValid),
    .IRespData   (IRespData),
    .FifoWData   (FifoWData),
    .FifoWInc    (FifoWInc),
    .WFull       (WFull),
    .W_Will_Full (W_Will_Full)
`ifdef IFU_PERF_EN
    ,
    .PerfIssueCnt(PerfIssueCnt),
    .PerfDropCnt (PerfDropCnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } mreq_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  int          checks = 0;
  int          errors = 0;
  int          issues = 0;
  int          drops  = 0;
  logic [31:0] exp_pc;
  bit          mem_hold;
  mreq_t       mem_q[$];
  logic [63:0] sb_q[$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode: 0 don't care, 1 expect no issue, 2 expect issue, 3 reset-state outputs
  task automatic tick(input int mode);
    mreq_t r;
    bit    exp_winc;
    exp_winc = 1'b0;
    if (!Rst && !mem_hold && mem_q.size() > 0) begin
      r          = mem_q.pop_front();
      IRespValid = 1'b1;
      IRespData  = inst_of(r.addr);
      if (!r.stale && !Jump) begin
        sb_q.push_back({r.addr, inst_of(r.addr)});
        exp_winc = 1'b1;
      end else begin
        drops++;
      end
    end else begin
      IRespValid = 1'b0;
      IRespData  = '0;
    end
    if (Jump && !Rst) foreach (mem_q[i]) mem_q[i].stale = 1'b1;
    #1;
    if (mode == 1) check("no_issue", IReqValid, 1'b0);
    if (mode == 2) check("issue", IReqValid, 1'b1);
    if (mode == 3) begin
      check("rst_ireqvalid", IReqValid, 1'b0);
      check("rst_fifowinc", FifoWInc, 1'b0);
      check("rst_fifowdata", FifoWData, 64'd0);
    end
    if (IReqValid && IReqReady) begin
      check("req_addr", IReqAddr, exp_pc);
      mem_q.push_back('{IReqAddr, 1'b0});
      exp_pc = exp_pc + 32'd4;
      issues++;
    end
    if (Jump && !Rst) exp_pc = JumpAddr;
    if (IRespValid || FifoWInc) check("fifo_winc", FifoWInc, exp_winc);
    if (FifoWInc && exp_winc) check("fifo_wdata", FifoWData, sb_q.pop_front());
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Rst        = 1'b1;
    Jump       = 1'b0;
    IRespValid = 1'b0;
    mem_q.delete();
    tick(3);
    tick(3);
    sb_q.delete();
    Rst    = 1'b0;
    exp_pc = RESET_PC;
    issues = 0;
    drops  = 0;
  endtask

  task automatic drain();
    IReqReady = 1'b0;
    repeat (3) tick(0);
  endtask

  initial begin
    Rst         = 1'b1;
    Jump        = 1'b0;
    JumpAddr    = '0;
    IReqReady   = 1'b1;
    IRespValid  = 1'b0;
    IRespData   = '0;
    WFull       = 1'b0;
    W_Will_Full = 1'b0;
    mem_hold    = 1'b0;
    exp_pc      = RESET_PC;
    @(negedge Clk);
    do_reset();

    // 1: streaming fetch, one-cycle memory
    tick(1);
    repeat (4) tick(2);

    // 2: FIFO full stalls issue without skipping a PC
    WFull = 1'b1;
    repeat (5) tick(1);
    WFull = 1'b0;
    tick(2);
    drain();

    // 3: one slot left with one in flight blocks a second issue
    IReqReady   = 1'b1;
    W_Will_Full = 1'b1;
    mem_hold    = 1'b1;
    tick(2);
    repeat (3) tick(1);
    mem_hold = 1'b0;
    tick(1);
    tick(2);
    W_Will_Full = 1'b0;
    drain();

    // 4: redirect with two in flight drains both
    IReqReady = 1'b1;
    mem_hold  = 1'b1;
    tick(2);
    tick(2);
    Jump     = 1'b1;
    JumpAddr = 32'h8000_1000;
    tick(1);
    Jump     = 1'b0;
    mem_hold = 1'b0;
    tick(1);
    tick(1);
    tick(2);
    check("jump_target", exp_pc, 32'h8000_1004);
    drain();

    // 5: redirect coinciding with the only live response
    IReqReady = 1'b1;
    mem_hold  = 1'b1;
    tick(2);
    Jump     = 1'b1;
    JumpAddr = 32'h8000_2000;
    mem_hold = 1'b0;
    tick(1);
    Jump = 1'b0;
    tick(2);
    drain();

    // 6: PC wrap at the top of the address space
    Jump     = 1'b1;
    JumpAddr = 32'hFFFF_FFFC;
    tick(1);
    Jump      = 1'b0;
    IReqReady = 1'b1;
    tick(2);
    tick(2);
    check("wrap_next_pc", exp_pc, 32'h0000_0004);
    drain();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
`ifdef IFU_PERF_EN
    check("perf_issue", PerfIssueCnt, 32'(issues));
    check("perf_drop", PerfDropCnt, 32'(drops));
`endif

    // reset while fetches are in flight
    IReqReady = 1'b1;
    tick(0);
    tick(0);
    do_reset();
    tick(1);
    tick(2);
    drain();
    check("sb_empty_final", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
